// File: rtl/input_channel.sv
// input_channel: router input port facing the link.
// Flits arrive over a val/ack handshake into a small FIFO. The head flit is
// XY-routed and a registered one-hot request is held toward the crossbar
// until the end-of-packet flit has been read by the granted output.
// Optional build macro: INPUT_CHANNEL_PKT_COUNT_EN enables the saturating
// forwarded-packet counter on pkt_count; otherwise pkt_count is tied to 0.
//
// Handshake: a link flit is transferred on every cycle where in_val and
// in_ack are both high; in_ack depends only on in_val and FIFO fullness, so
// the link may not make in_val wait on in_ack. Toward the crossbar, the head
// flit is consumed on a cycle where x_rok is high and x_rd is asserted on the
// currently requested index.
module input_channel #(
    parameter int       DATA_WIDTH      = 70,
    parameter int       NUMBER_CHANNELS = 5,
    parameter int       FIFO_DEPTH      = 4,
    parameter bit [3:0] X_LOCAL         = 4'd0,
    parameter bit [3:0] Y_LOCAL         = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_val,
    output logic                       in_ack,
    output logic [NUMBER_CHANNELS-1:0] x_req,
    input  logic [NUMBER_CHANNELS-1:0] x_gnt,
    input  logic [NUMBER_CHANNELS-1:0] x_rd,
    output logic                       x_rok,
    output logic [DATA_WIDTH-1:0]      x_dout,
    output logic                       drop,
    output logic [15:0]                pkt_count,
    output logic [1:0]                 state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_FORWARD  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NUMBER_CHANNELS-1:0] req_q, req_d;
    logic                       drop_q, drop_d;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      head;
    logic [NUMBER_CHANNELS-1:0] route;
    logic                       full, empty, push, pop;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign in_ack = in_val & ~full;
    assign push   = in_ack;
    assign head   = mem_q[rd_ptr_q];
    assign x_rok  = ~empty;
    assign x_dout = head;
    assign x_req  = req_q;
    assign drop   = drop_q;
    assign state_dbg = state_q;

    // Flit storage; contents need no reset since x_rok gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses pushes even while popping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // XY routing of the head flit: resolve X first, then Y, else local.
    always_comb begin
        route = '0;
        if (head[7:4] > X_LOCAL)      route[2] = 1'b1;
        else if (head[7:4] < X_LOCAL) route[4] = 1'b1;
        else if (head[3:0] > Y_LOCAL) route[1] = 1'b1;
        else if (head[3:0] < Y_LOCAL) route[3] = 1'b1;
        else                          route[0] = 1'b1;
    end

    // Packet FSM state, held request and orphan-drop pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: latch route on a header, wait for grant, forward until eop.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        drop_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (x_rok) begin
                    if (head[DATA_WIDTH-1]) begin
                        req_d   = route;
                        state_d = S_WAIT_GNT;
                    end else begin
                        pop    = 1'b1;
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT_GNT: begin
                if (|(x_gnt & req_q)) state_d = S_FORWARD;
            end
            S_FORWARD: begin
                if (x_rok && (|(x_rd & req_q))) begin
                    pop = 1'b1;
                    if (head[DATA_WIDTH-2]) begin
                        req_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
            end
        endcase
    end

`ifdef INPUT_CHANNEL_PKT_COUNT_EN
    logic        eop_pop;
    logic [15:0] pkt_q;

    assign eop_pop   = (state_q == S_FORWARD) & pop & head[DATA_WIDTH-2];
    assign pkt_count = pkt_q;

    // Saturating count of packets whose eop flit was forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_q <= '0;
        end else if (eop_pop && (pkt_q != 16'hFFFF)) begin
            pkt_q <= pkt_q + 16'd1;
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_input_channel.sv
// Directed testbench for input_channel at local coordinates (1,1).
// Stimulus pushes accepted, non-orphan flits into exp_q; a negedge monitor
// pops and compares each flit the DUT hands to the requested output.
module tb_input_channel;

    localparam int DW = 70;
    localparam int NC = 5;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_val;
    logic          in_ack;
    logic [NC-1:0] x_req;
    logic [NC-1:0] x_gnt;
    logic [NC-1:0] x_rd;
    logic          x_rok;
    logic [DW-1:0] x_dout;
    logic          drop;
    logic [15:0]   pkt_count;
    logic [1:0]    state_dbg;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_flit;
    logic [15:0]   exp_pkt;
    logic [DW-1:0] f4 [5];
    logic [DW-1:0] hdr, body, tail;
    int            tests;
    int            failed;

    input_channel #(
        .DATA_WIDTH(DW), .NUMBER_CHANNELS(NC), .FIFO_DEPTH(4),
        .X_LOCAL(4'd1), .Y_LOCAL(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_ack(in_ack),
        .x_req(x_req), .x_gnt(x_gnt), .x_rd(x_rd), .x_rok(x_rok), .x_dout(x_dout),
        .drop(drop), .pkt_count(pkt_count), .state_dbg(state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mk(input logic bop, input logic eop,
                                         input logic [59:0] pl,
                                         input logic [3:0] dx, input logic [3:0] dy);
        return {bop, eop, pl, dx, dy};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one flit on the link until accepted (bounded wait).
    task automatic push_flit(input logic [DW-1:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        in_data = d;
        in_val  = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (in_ack) begin
                ok = 1'b1;
                if (keep) exp_q.push_back(d);
            end
            tick();
        end
        in_val = 1'b0;
        if (!ok) begin
            tests++;
            failed++;
            $display("FAIL push_timeout: got no in_ack expected in_ack within 20 cycles");
        end
    endtask

    // Route a header, reach FORWARD, then reset asynchronously mid-packet.
    task automatic route_case(input logic [3:0] dx, input logic [3:0] dy, input logic [NC-1:0] exp_req);
        push_flit(mk(1'b1, 1'b0, 60'h0ABC, dx, dy), 1'b0);
        push_flit(mk(1'b0, 1'b0, 60'h0DEF, dx, dy), 1'b0);
        check("route_req", x_req, exp_req);
        x_gnt = exp_req;
        tick();
        check("route_fwd_state", state_dbg, 2);
        x_gnt = '0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", x_req, 0);
        check("async_rst_rok", x_rok, 0);
        check("async_rst_pkt", pkt_count, 0);
        check("async_rst_state", state_dbg, 0);
        exp_q.delete();
        exp_pkt = '0;
        tick();
        rst = 1'b1;
    endtask

    // Monitor: every head-flit read by the requested output is compared in order.
    always @(negedge clk) begin
        if (rst && x_rok && (|(x_rd & x_req))) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pop: got %h expected none", x_dout);
            end else begin
                exp_flit = exp_q.pop_front();
                check("fwd_flit", x_dout, exp_flit);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        tests = 0; failed = 0; exp_pkt = '0;
        rst = 1'b0; in_val = 1'b0; in_data = '0; x_gnt = '0; x_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", x_req, 0);
        check("rst_rok", x_rok, 0);
        check("rst_drop", drop, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b1;
        tick();

        // Three-flit packet routed East
        hdr  = mk(1'b1, 1'b0, 60'h111, 4'd2, 4'd0);
        body = mk(1'b0, 1'b0, 60'h222, 4'd7, 4'd7);
        tail = mk(1'b0, 1'b1, 60'h333, 4'd3, 4'd3);
        push_flit(hdr, 1'b1);
        check("hdr_rok", x_rok, 1);
        check("req_not_yet", x_req, 0);
        push_flit(body, 1'b1);
        check("req_east", x_req, 5'b00100);
        check("wait_state", state_dbg, 1);
        push_flit(tail, 1'b1);
        x_gnt = 5'b00010;
        tick();
        check("wrong_gnt_state", state_dbg, 1);
        x_gnt = 5'b00100;
        tick();
        check("fwd_state", state_dbg, 2);
        x_rd = 5'b01000;
        tick();
        check("wrong_rd_state", state_dbg, 2);
        check("wrong_rd_head", x_dout, hdr);
        x_rd = 5'b00100;
        repeat (3) tick();
        x_rd = '0;
        x_gnt = '0;
        check("east_done_req", x_req, 0);
        check("east_done_rok", x_rok, 0);
        check("east_done_state", state_dbg, 0);

        // Single-flit packet to Local
        push_flit(mk(1'b1, 1'b1, 60'h444, 4'd1, 4'd1), 1'b1);
        tick();
        check("req_local", x_req, 5'b00001);
        x_gnt = 5'b00001;
        tick();
        x_rd = 5'b00001;
        tick();
        x_rd = '0;
        x_gnt = '0;
        check("local_done_req", x_req, 0);
        check("local_done_state", state_dbg, 0);
        check("local_done_rok", x_rok, 0);
`ifdef INPUT_CHANNEL_PKT_COUNT_EN
        exp_pkt = 16'd2;
`endif
        check("pkt_after_two", pkt_count, exp_pkt);

        // Orphan flit discarded in IDLE
        push_flit(mk(1'b0, 1'b0, 60'h555, 4'd2, 4'd2), 1'b0);
        check("orphan_rok", x_rok, 1);
        check("orphan_drop_pre", drop, 0);
        tick();
        check("orphan_drop", drop, 1);
        check("orphan_rok_gone", x_rok, 0);
        check("orphan_req", x_req, 0);
        tick();
        check("orphan_drop_end", drop, 0);
        check("pkt_after_orphan", pkt_count, exp_pkt);

        // Fill to capacity, then pop while full
        f4[0] = mk(1'b1, 1'b0, 60'hA0, 4'd2, 4'd1);
        f4[1] = mk(1'b0, 1'b0, 60'hA1, 4'd0, 4'd0);
        f4[2] = mk(1'b0, 1'b0, 60'hA2, 4'd0, 4'd0);
        f4[3] = mk(1'b0, 1'b0, 60'hA3, 4'd0, 4'd0);
        f4[4] = mk(1'b0, 1'b1, 60'hA4, 4'd0, 4'd0);
        x_gnt = 5'b00100;
        for (int i = 0; i < 6; i++) begin
            in_val  = 1'b1;
            in_data = (i < 4) ? f4[i] : f4[4];
            @(negedge clk);
            check("ack_fill", in_ack, (i < 4));
            if (i < 4) exp_q.push_back(f4[i]);
            tick();
        end
        check("full_fwd_state", state_dbg, 2);
        in_data = f4[4];
        x_rd = 5'b00100;
        @(negedge clk);
        check("ack_full_pop", in_ack, 0);
        tick();
        x_rd = '0;
        @(negedge clk);
        check("ack_after_pop", in_ack, 1);
        exp_q.push_back(f4[4]);
        tick();
        in_val = 1'b0;
        x_rd = 5'b00100;
        repeat (4) tick();
        x_rd = '0;
        x_gnt = '0;
        check("full_done_rok", x_rok, 0);
        check("full_done_req", x_req, 0);
        check("full_done_state", state_dbg, 0);
`ifdef INPUT_CHANNEL_PKT_COUNT_EN
        exp_pkt = 16'd3;
`endif
        check("pkt_after_three", pkt_count, exp_pkt);
        check("exp_q_drained", exp_q.size(), 0);

        // Routing table with asynchronous reset mid-packet
        route_case(4'd1, 4'd2, 5'b00010);
        route_case(4'd1, 4'd0, 5'b01000);
        route_case(4'd0, 4'd1, 5'b10000);
        route_case(4'd0, 4'd5, 5'b10000);
        route_case(4'd15, 4'd15, 5'b00100);
        route_case(4'd1, 4'd1, 5'b00001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
